// File: rtl/synapse_row_scheduler_pkg.sv
// Shared types and constants for the synapse row scheduler:
// FSM state enum, current width/limits, weight-pair field positions.
package synapse_row_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CALC,
    S_OUT,
    S_DONE
  } state_e;

  localparam int CUR_W   = 6;
  localparam int CUR_MAX = 31;
  localparam int CUR_MIN = -32;

  localparam int W_ZERO_BIT = 0;
  localparam int W_SIGN_BIT = 1;

  function automatic logic signed [CUR_W-1:0]
    clamp_cur(input int v);
    if (v > CUR_MAX) begin
      return CUR_W'(CUR_MAX);
    end else if (v < CUR_MIN) begin
      return CUR_W'(CUR_MIN);
    end
    return CUR_W'(v);
  endfunction

endpackage

// File: rtl/synapse_row_scheduler_if.sv
// Weight-memory read port plus current valid/ready output channel.
// master: scheduler side; slave: memory + downstream consumer side.
interface synapse_row_scheduler_if
  import synapse_row_scheduler_pkg::*;
#(
  parameter int M  = 4,
  parameter int AW = 3
);

  logic                    weight_rd_en;
  logic [AW-1:0]           weight_addr;
  logic [2*M-1:0]          weight_rdata;
  logic                    current_valid;
  logic                    current_ready;
  logic signed [CUR_W-1:0] current_value;
  logic [AW-1:0]           current_neuron;

  modport master (
    output weight_rd_en,
    output weight_addr,
    input  weight_rdata,
    output current_valid,
    input  current_ready,
    output current_value,
    output current_neuron
  );

  modport slave (
    input  weight_rd_en,
    input  weight_addr,
    output weight_rdata,
    input  current_valid,
    output current_ready,
    input  current_value,
    input  current_neuron
  );

endinterface

// File: rtl/synapse_row_scheduler_sum.sv
// Signed sum of spike-gated +/-1 synapse weights, clamped to 6 bits.
// Ports: spikes_i (M), weights_i (2*M pairs {sign,zero}), sum_o.
module spike_weight_sum
  import synapse_row_scheduler_pkg::*;
#(
  parameter int M = 4
) (
  input  logic [M-1:0]            spikes_i,
  input  logic [2*M-1:0]          weights_i,
  output logic signed [CUR_W-1:0] sum_o
);

  int acc;

  always_comb begin
    acc = 0;
    for (int i = 0; i < M; i++) begin
      if (spikes_i[i] &&
          !weights_i[2*i+W_ZERO_BIT]) begin
        if (weights_i[2*i+W_SIGN_BIT]) begin
          acc = acc - 1;
        end else begin
          acc = acc + 1;
        end
      end
    end
    sum_o = clamp_cur(acc);
  end

endmodule

// File: rtl/synapse_row_scheduler.sv
// Per-layer scheduler: fetch each neuron's weight row, form its input current.
// Ports: clk, reset_n, start, abort, input_spikes, bus (master), busy, done.
module synapse_row_scheduler
  import synapse_row_scheduler_pkg::*;
#(
  parameter int M  = 4,
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic [M-1:0] input_spikes,
  synapse_row_scheduler_if.master bus,
  output logic         busy,
  output logic         done
);

  state_e                  state_q, state_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic [M-1:0]            spk_q, spk_d;
  logic signed [CUR_W-1:0] val_q, val_d;
  logic [AW-1:0]           nrn_q, nrn_d;
  logic                    vld_q, vld_d;
  logic signed [CUR_W-1:0] sum;

  spike_weight_sum #(.M(M)) u_sum (
    .spikes_i  (spk_q),
    .weights_i (bus.weight_rdata),
    .sum_o     (sum)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      spk_q   <= '0;
      val_q   <= '0;
      nrn_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      spk_q   <= spk_d;
      val_q   <= val_d;
      nrn_q   <= nrn_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    spk_d   = spk_q;
    val_d   = val_q;
    nrn_d   = nrn_q;
    vld_d   = vld_q;
    // abort outranks any handshake in flight
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      vld_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            spk_d   = input_spikes;
            idx_d   = '0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: state_d = S_CALC;
        S_CALC: begin
          val_d   = sum;
          nrn_d   = idx_q;
          vld_d   = 1'b1;
          state_d = S_OUT;
        end
        S_OUT: begin
          if (bus.current_ready) begin
            vld_d = 1'b0;
            if (idx_q == AW'(N-1)) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + AW'(1);
              state_d = S_FETCH;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.weight_rd_en   = (state_q == S_FETCH);
  assign bus.weight_addr    = idx_q;
  assign bus.current_valid  = vld_q;
  assign bus.current_value  = val_q;
  assign bus.current_neuron = nrn_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_synapse_row_scheduler.sv
// Self-checking bench for synapse_row_scheduler (N=8/M=4 and N=2/M=31).
// Random spikes/rows checked against a spike-count reference model.
module tb_synapse_row_scheduler;

  localparam int M   = 4;
  localparam int N   = 8;
  localparam int AW  = 3;
  localparam int M2  = 31;
  localparam int N2  = 2;
  localparam int AW2 = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [M-1:0]  spikes = '0;
  logic          busy, done;
  logic          start2 = 1'b0;
  logic          abort2 = 1'b0;
  logic [M2-1:0] spikes2 = '0;
  logic          busy2, done2;

  int vectors = 0;
  int errs = 0;
  int done_cnt = 0;
  int obs [N];

  logic [2*M-1:0]  mem  [N];
  logic [2*M2-1:0] mem2 [N2];

  synapse_row_scheduler_if #(.M(M), .AW(AW)) bus ();
  synapse_row_scheduler_if #(.M(M2), .AW(AW2)) bus2 ();

  synapse_row_scheduler #(.M(M), .N(N)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .input_spikes (spikes),
    .bus          (bus),
    .busy         (busy),
    .done         (done)
  );

  synapse_row_scheduler #(.M(M2), .N(N2)) dut2 (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start2),
    .abort        (abort2),
    .input_spikes (spikes2),
    .bus          (bus2),
    .busy         (busy2),
    .done         (done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.weight_rd_en) bus.weight_rdata <= mem[bus.weight_addr];
    if (bus2.weight_rd_en) bus2.weight_rdata <= mem2[bus2.weight_addr];
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Net current = (active positive synapses) - (active negative synapses),
  // saturated to the 6-bit signed range.
  function automatic int model_cur(input logic [M-1:0] s,
                                   input logic [2*M-1:0] w);
    int pos = 0;
    int neg = 0;
    for (int i = 0; i < M; i++) begin
      if (s[i] == 1'b1 && w[2*i] == 1'b0) begin
        if (w[2*i+1]) neg++;
        else pos++;
      end
    end
    if (pos - neg > 31) return 31;
    if (pos - neg < -32) return -32;
    return pos - neg;
  endfunction

  task automatic chk(input string tag,
                     input logic signed [31:0] o,
                     input logic signed [31:0] e);
    vectors++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input logic [M-1:0] spk,
                          input int stall_at,
                          input int stall_len,
                          input bit noisy);
    int k, t, st, seen;
    bit fin;
    k = 0; t = 0; st = 0; seen = -1; fin = 0;
    start = 1'b1;
    spikes = spk;
    bus.current_ready = 1'b1;
    step();
    start = 1'b0;
    chk("fetch0_rd_en", bus.weight_rd_en, 1);
    while (!fin && t < 40*N) begin
      if (bus.weight_rd_en) chk("fetch_addr", bus.weight_addr, k);
      if (bus.current_valid) begin
        chk("neuron", bus.current_neuron, k);
        chk("value", $signed(bus.current_value),
            model_cur(spk, mem[k]));
        if (seen != k) begin
          chk("valid_time", t, 2 + 3*k + st);
          obs[k] = int'($signed(bus.current_value));
          seen = k;
        end
      end
      if (done) begin
        chk("done_count", k, N);
        chk("done_time", t, 3*N + st);
        fin = 1;
        start = 1'b0;
      end else if (noisy && busy) begin
        start = 1'($urandom_range(0, 1));
      end
      spikes = M'($urandom);
      if (k == stall_at && bus.current_valid && st < stall_len) begin
        bus.current_ready = 1'b0;
        st++;
        chk("stall_no_rd", bus.weight_rd_en, 0);
      end else begin
        bus.current_ready = 1'b1;
        if (bus.current_valid) k++;
      end
      if (!fin) begin
        step();
        t++;
      end
    end
    chk("pass_finished", fin, 1);
    start = 1'b0;
    step();
    chk("idle_after", busy, 0);
  endtask

  task automatic abort_pass(input logic [M-1:0] spk, input int at);
    bit hit;
    int d0;
    hit = 0;
    start = 1'b1;
    spikes = spk;
    bus.current_ready = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 40*N && !hit; n++) begin
      if (bus.current_valid && bus.current_neuron == AW'(at)) hit = 1;
      else step();
    end
    chk("abort_reach", hit, 1);
    d0 = done_cnt;
    abort = 1'b1;
    bus.current_ready = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", bus.current_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (3) step();
    chk("abort_no_done", done_cnt, d0);
  endtask

  task automatic rand_rows();
    for (int i = 0; i < N; i++) mem[i] = (2*M)'($urandom);
  endtask

  initial begin
    bus.current_ready = 1'b0;
    bus2.current_ready = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", bus.current_valid, 0);
    chk("rst_rd_en", bus.weight_rd_en, 0);
    chk("rst_value", bus.current_value, 0);
    chk("rst_neuron", bus.current_neuron, 0);
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // all spikes, all rows zero: +4 per neuron
    run_pass(4'b1111, -1, 0, 0);
    for (int i = 0; i < N; i++) chk("all_pos", obs[i], 4);

    // directed rows: mixed -> 0, three negatives -> -3
    rand_rows();
    mem[0] = 8'h84;
    mem[1] = 8'h8A;
    run_pass(4'b1011, -1, 0, 0);
    chk("mix_zero", obs[0], 0);
    chk("three_neg", obs[1], -3);

    // stall neuron 2 for 5 cycles
    rand_rows();
    run_pass(M'($urandom), 2, 5, 0);

    for (int p = 0; p < 4; p++) begin
      rand_rows();
      run_pass(M'($urandom), $urandom_range(0, N-1),
               $urandom_range(0, 3), 0);
    end

    // abort in OUT of neuron 4, then restart from 0
    rand_rows();
    abort_pass(M'($urandom), 4);
    run_pass(M'($urandom), -1, 0, 0);

    // start and abort together in IDLE: start wins
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    chk("start_wins_busy", busy, 1);
    chk("start_wins_rd", bus.weight_rd_en, 1);
    chk("start_wins_addr", bus.weight_addr, 0);
    step();
    abort = 1'b0;
    chk("abort_fetch_busy", busy, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", busy, 0);

    // async reset during CALC
    start = 1'b1;
    spikes = 4'b1111;
    step();
    start = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_valid", bus.current_valid, 0);
    chk("mid_rst_rd_en", bus.weight_rd_en, 0);
    chk("mid_rst_value", bus.current_value, 0);
    chk("mid_rst_neuron", bus.current_neuron, 0);
    #2;
    reset_n = 1'b1;
    step();
    rand_rows();
    run_pass(M'($urandom), -1, 0, 1);
    rand_rows();
    run_pass(M'($urandom), 5, 2, 1);

    // wide parameterisation: saturating sums
    mem2[0] = '0;
    mem2[1] = {M2{2'b10}};
    spikes2 = '1;
    bus2.current_ready = 1'b1;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    spikes2 = '0;
    begin
      int got;
      bit fin2;
      got = 0;
      fin2 = 0;
      for (int c = 0; c < 40 && !fin2; c++) begin
        if (bus2.current_valid) begin
          if (got == 0) chk("m31_pos", $signed(bus2.current_value), 31);
          else chk("m31_neg", $signed(bus2.current_value), -31);
          chk("m31_neuron", bus2.current_neuron, got);
          got++;
        end
        if (done2) fin2 = 1;
        else step();
      end
      chk("m31_done", fin2, 1);
      chk("m31_count", got, N2);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
